// File: rtl/quad_encoder_ctrl.sv
// quad_encoder_ctrl: synchronised, debounced quadrature decoder with a
// per-detent position counter, plus a short/normal/long pushbutton classifier.
module quad_encoder_ctrl #(
    parameter int CNT_W    = 8,
    parameter int CNT_INIT = 128,
    parameter int CNT_MIN  = 0,
    parameter int CNT_MAX  = 255,
    parameter int WRAP     = 0,
    parameter int QPD      = 4,
    parameter int FILT_LEN = 4,
    parameter int PB_W     = 12,
    parameter int T_SHORT  = 50,
    parameter int T_NORMAL = 400,
    parameter int T_LONG   = 3000,
    parameter int LONG_CLR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             pb,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             quad_err,
    output logic             press_valid,
    output logic [1:0]       press_type
);
    localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] INIT_V = CNT_W'(CNT_INIT);
    localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(CNT_MAX);
    localparam logic signed [3:0] QPD_P = 4'(QPD);
    localparam logic signed [3:0] QPD_N = -QPD_P;
    localparam logic [PB_W-1:0] T_SHORT_V  = PB_W'(T_SHORT);
    localparam logic [PB_W-1:0] T_NORMAL_V = PB_W'(T_NORMAL);
    localparam logic [PB_W-1:0] T_LONG_V   = PB_W'(T_LONG);

    // Channel order: 0 = A, 1 = B, 2 = PB (idle-high)
    logic [2:0] raw;
    logic [2:0] filt;
    assign raw = {pb, b, a};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            localparam logic RST_V = (gi == 2) ? 1'b1 : 1'b0;
            logic          sync1_q, sync2_q, filt_q, filt_d;
            logic [FW-1:0] stab_q, stab_d;

            // Accept the synced value once it has differed for FILT_LEN samples
            always_comb begin
                filt_d = filt_q;
                stab_d = '0;
                if (sync2_q != filt_q) begin
                    if (stab_q == FW'(FILT_LEN - 1)) begin
                        filt_d = sync2_q;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
            end

            // Two-flop synchroniser followed by the filter state
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= RST_V;
                    sync2_q <= RST_V;
                    filt_q  <= RST_V;
                    stab_q  <= '0;
                end else begin
                    sync1_q <= raw[gi];
                    sync2_q <= sync1_q;
                    filt_q  <= filt_d;
                    stab_q  <= stab_d;
                end
            end

            assign filt[gi] = filt_q;
        end
    endgenerate

    logic [1:0] ab_cur, ab_prev_q;
    logic       qs_up, qs_dn, qerr_hit;
    assign ab_cur = {filt[0], filt[1]};

    // Gray-code decode of the previous vs current filtered {A,B}
    always_comb begin
        qs_up    = 1'b0;
        qs_dn    = 1'b0;
        qerr_hit = 1'b0;
        case ({ab_prev_q, ab_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: qs_up    = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: qs_dn    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: qerr_hit = 1'b1;
            default: ;
        endcase
    end

    typedef enum logic [1:0] {P_IDLE, P_PRESSED, P_HELD} press_state_t;
    press_state_t    pstate_q, pstate_d;
    logic [PB_W-1:0] dur_q, dur_d;
    logic            pv_q, pv_d;
    logic [1:0]      ptype_q, ptype_d;
    logic            long_clr;

    // Press FSM: time the filtered press and classify it
    always_comb begin
        pstate_d = pstate_q;
        dur_d    = dur_q;
        pv_d     = 1'b0;
        ptype_d  = ptype_q;
        long_clr = 1'b0;
        case (pstate_q)
            P_IDLE: begin
                dur_d = '0;
                if (!filt[2]) begin
                    pstate_d = P_PRESSED;
                    dur_d    = PB_W'(1);
                end
            end
            P_PRESSED: begin
                if (dur_q >= T_LONG_V) begin
                    // Duration reached T_LONG with the button still down
                    pv_d     = 1'b1;
                    ptype_d  = 2'b11;
                    long_clr = (LONG_CLR != 0);
                    pstate_d = P_HELD;
                end else if (filt[2]) begin
                    pstate_d = P_IDLE;
                    dur_d    = '0;
                    if (dur_q >= T_NORMAL_V) begin
                        pv_d    = 1'b1;
                        ptype_d = 2'b10;
                    end else if (dur_q >= T_SHORT_V) begin
                        pv_d    = 1'b1;
                        ptype_d = 2'b01;
                    end
                end else if (dur_q != '1) begin
                    dur_d = dur_q + 1'b1;
                end
            end
            P_HELD: begin
                if (filt[2]) begin
                    pstate_d = P_IDLE;
                    dur_d    = '0;
                end
            end
            default: pstate_d = P_IDLE;
        endcase
    end

    logic signed [3:0] acc_q, acc_d, acc_nx;
    logic              det_up, det_dn;
    logic [CNT_W-1:0]  count_q, count_d, count_inc, count_dec;
    logic              dir_q, dir_d, step_q, step_d, qerr_q;

    // Detent accumulator and count update with clear priority
    always_comb begin
        acc_nx = acc_q;
        det_up = 1'b0;
        det_dn = 1'b0;
        if (qs_up) begin
            acc_nx = acc_q[3] ? 4'sd1 : acc_q + 4'sd1;
            if (acc_nx == QPD_P) begin
                det_up = 1'b1;
                acc_nx = '0;
            end
        end else if (qs_dn) begin
            acc_nx = (!acc_q[3] && acc_q != 4'sd0) ? -4'sd1 : acc_q - 4'sd1;
            if (acc_nx == QPD_N) begin
                det_dn = 1'b1;
                acc_nx = '0;
            end
        end
        acc_d = acc_nx;

        count_inc = count_q + 1'b1;
        count_dec = count_q - 1'b1;
        if (WRAP == 0) begin
            if (count_q == MAX_V) count_inc = count_q;
            if (count_q == MIN_V) count_dec = count_q;
        end

        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        if (clr || long_clr) begin
            count_d = INIT_V;
        end else if (det_up) begin
            count_d = count_inc;
            dir_d   = 1'b1;
            step_d  = 1'b1;
        end else if (det_dn) begin
            count_d = count_dec;
            dir_d   = 1'b0;
            step_d  = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ab_prev_q <= 2'b00;
            acc_q     <= '0;
            count_q   <= INIT_V;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
            qerr_q    <= 1'b0;
            pstate_q  <= P_IDLE;
            dur_q     <= '0;
            pv_q      <= 1'b0;
            ptype_q   <= 2'b00;
        end else begin
            ab_prev_q <= ab_cur;
            acc_q     <= acc_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            qerr_q    <= qerr_hit;
            pstate_q  <= pstate_d;
            dur_q     <= dur_d;
            pv_q      <= pv_d;
            ptype_q   <= ptype_d;
        end
    end

    assign count       = count_q;
    assign dir         = dir_q;
    assign step        = step_q;
    assign quad_err    = qerr_q;
    assign press_valid = pv_q;
    assign press_type  = ptype_q;
endmodule

// File: doc/quad_encoder_ctrl.md
Name: quad_encoder_ctrl

Overview:
Parametrised quadrature rotary-encoder and pushbutton controller, the successor of the 4-bit single-edge encoder block. It synchronises and debounces A/B/PB and decodes all four Gray-code transitions. A configurable-width position counter, with wrap or saturate mode, advances once per detent. Button presses are classified into short/normal/long, and a long press is reported while the button is still held. It sits between the board-level encoder pins and the UI/menu logic.

Parameters:
CNT_W, 8, position counter width (2..16)
CNT_INIT, 128, count value after reset, clr, or long-press clear
CNT_MIN, 0, lower count bound (saturate mode)
CNT_MAX, 255, upper count bound (saturate mode); CNT_MIN <= CNT_INIT <= CNT_MAX
WRAP, 0, 1 = modulo 2^CNT_W wrap; 0 = saturate at CNT_MIN/CNT_MAX
QPD, 4, quarter-steps per detent (1, 2 or 4)
FILT_LEN, 4, consecutive stable samples required to accept an input change (>=1)
PB_W, 12, press-duration counter width
T_SHORT, 50, minimum cycles for a valid press
T_NORMAL, 400, short/normal boundary
T_LONG, 3000, normal/long boundary (< 2^PB_W)
LONG_CLR, 1, 1 = long press reloads count to CNT_INIT

Ports:
clk  in  1  system clock (1 kHz tick domain)
rst  in  1  reset, synchronous, active-high
a  in  1  encoder channel A, asynchronous
b  in  1  encoder channel B, asynchronous
pb  in  1  pushbutton, asynchronous, active-low (0 = pressed)
clr  in  1  synchronous count reload to CNT_INIT
count  out  CNT_W  position value
dir  out  1  direction of last count change (1 = CW/up)
step  out  1  one-cycle pulse when count changes
quad_err  out  1  one-cycle pulse on an illegal A/B transition (both changed)
press_valid  out  1  one-cycle pulse when press_type is updated
press_type  out  2  01 short, 10 normal, 11 long; held until next report

Behaviour:
- Reset (rst=1 at posedge clk) sets:
  - count=CNT_INIT, dir=0, step=0, quad_err=0, press_valid=0, press_type=00
  - sync flops, filtered A/B = 0, filtered PB = 1; quarter-step accumulator 0; press FSM IDLE, duration 0
  - Reset mid-press or mid-detent discards all partial state.
- Input path: 2-FF synchroniser per input, then a per-channel debounce filter.
  - Filtered value takes the synced value on the clock edge where it has differed from the filtered value for FILT_LEN consecutive cycles.
  - Any sample equal to the filtered value clears that channel's stability counter.
  - Latency from raw pin edge to filtered edge: FILT_LEN+2 cycles.
- Decode: compare previous and current filtered {A,B}.
  - 00->10->11->01->00 = +1 quarter-step; reverse order = -1.
  - Both bits changing in one cycle: no step, quad_err pulses, state still updates.
- Detent accumulator: signed, range +-QPD.
  - Reaching +QPD: count increments, dir=1, step pulses, accumulator=0.
  - Reaching -QPD: count decrements, dir=0, step pulses, accumulator=0.
  - A quarter-step opposite to the accumulator sign resets the accumulator to 0 before applying it.
- Count arithmetic:
  - WRAP=1: modulo 2^CNT_W.
  - WRAP=0: clamp at CNT_MAX/CNT_MIN. An increment at CNT_MAX (or decrement at CNT_MIN) leaves count unchanged; step still pulses and dir is still updated.
- Count priority, highest first: rst > clr > long-press clear > detent step. A step in the same cycle as a clear is dropped and step stays 0.
- Count updates and step are registered: one cycle after the filtered edge that completes a detent.
- Press FSM states:
  - IDLE: filtered pb=0 -> PRESSED, duration=1.
  - PRESSED: duration increments each cycle, saturating at 2^PB_W-1. When duration reaches T_LONG while still held: press_valid pulses, press_type=11, count reloads if LONG_CLR, go to HELD. On release (filtered pb=1):
    - duration < T_SHORT: no report, go to IDLE
    - T_SHORT <= duration < T_NORMAL: report 01
    - T_NORMAL <= duration < T_LONG: report 10
    - after reporting, go to IDLE
  - HELD: wait for release -> IDLE; no second report.
- press_valid is asserted in the cycle after the deciding edge; press_type changes in the same cycle. Duration resets to 0 in IDLE.
- Encoder decoding continues during any press state.

Test Plan:
- Rotate CW one full Gray cycle (4 transitions, 20 cycles apart), QPD=4 -> count 128->129 once, step one pulse, dir=1, after the 4th filtered edge + 1 cycle.
- Toggle pin a for 3 cycles then back (FILT_LEN=4) -> filtered A unchanged, no step, no quad_err; a held 4+ cycles -> accepted after FILT_LEN+2 cycles.
- Three quarter-steps CW then one CCW -> no count change, accumulator reset; then 4 CCW -> count 127.
- WRAP=0, drive count to 255 and rotate CW one detent -> count stays 255, step pulses. WRAP=1 -> count 0.
- pb low for 30 / 200 / 1000 cycles -> no press_valid / type 01 / type 10. pb low 5000 cycles -> press_valid at cycle T_LONG+FILT_LEN+3, type 11, count=128, no report on release.
- Apply a detent completion in the same cycle as clr -> count=CNT_INIT, step=0. Assert rst mid-press for 1 cycle, then release -> no press_valid, all outputs at reset values.
